// File: rtl/level_timer_ctrl.sv
// Level countdown timer: BCD MM:SS budget decremented once per prescaled second,
// with start/pause/resume/abort control, warning window and a time-up pulse.
module level_timer_ctrl #(
  parameter int          TICK_DIV = 50000000,
  parameter int          CNT_W    = 26,
  parameter logic [7:0]  WARN_SS  = 8'h30
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       resume,
  input  logic       abort,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] state,
  output logic       tick,
  output logic       time_up,
  output logic       warning
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [7:0]       mm_q, mm_d, ss_q, ss_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d, time_up_q, time_up_d;

  logic [7:0]       san_mm, san_ss;
  logic [15:0]      dec_t;

  // One-second decrement of a valid, non-zero BCD MM:SS value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  always_comb begin
    san_mm = load_mm;
    if (load_mm[7:4] > 4'd9 || load_mm[3:0] > 4'd9) san_mm = 8'h99;
    san_ss = load_ss;
    if (load_ss[7:4] > 4'd5 || load_ss[3:0] > 4'd9) san_ss = 8'h59;
    dec_t = bcd_dec({mm_q, ss_q});
  end

  always_comb begin
    state_d   = state_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    time_up_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      mm_d    = 8'h00;
      ss_d    = 8'h00;
      pre_d   = '0;
    end else if (start && (state_q == S_IDLE || state_q == S_EXPIRED)) begin
      pre_d = '0;
      mm_d  = san_mm;
      ss_d  = san_ss;
      if (san_mm == 8'h00 && san_ss == 8'h00) begin
        state_d   = S_EXPIRED;
        // back-to-back zero starts must not stretch the pulse
        time_up_d = ~time_up_q;
      end else begin
        state_d = S_RUN;
      end
    end else if (pause && state_q == S_RUN) begin
      state_d = S_PAUSED;
    end else if (resume && state_q == S_PAUSED) begin
      state_d = S_RUN;
    end else if (state_q == S_RUN) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (mm_q == 8'h00 && ss_q == 8'h00) begin
          // unreachable in normal use; never wrap to 99:59
          state_d = S_EXPIRED;
          tick_d  = 1'b0;
        end else begin
          {mm_d, ss_d} = dec_t;
          if (dec_t == 16'h0000) begin
            state_d   = S_EXPIRED;
            time_up_d = 1'b1;
          end
        end
      end else begin
        pre_d = pre_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      time_up_q <= time_up_d;
    end
  end

  assign mm      = mm_q;
  assign ss      = ss_q;
  assign state   = state_q;
  assign tick    = tick_q;
  assign time_up = time_up_q;
  assign warning = (state_q == S_RUN || state_q == S_PAUSED) &&
                   mm_q == 8'h00 && ss_q <= WARN_SS;

endmodule

// File: tb/tb_level_timer_ctrl.sv
// Directed bench for level_timer_ctrl with TICK_DIV=4; expected values are hand-derived.
module tb_level_timer_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       resetn, start, pause, resume, abort;
  logic [7:0] load_mm, load_ss, mm, ss;
  logic [1:0] state;
  logic       tick, time_up, warning;
  int         checks = 0;
  int         errors = 0;

  level_timer_ctrl #(.TICK_DIV(4), .CNT_W(3), .WARN_SS(8'h30)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .pause(pause),
    .resume(resume), .abort(abort), .load_mm(load_mm), .load_ss(load_ss),
    .mm(mm), .ss(ss), .state(state), .tick(tick), .time_up(time_up),
    .warning(warning)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_start(input logic [7:0] m, input logic [7:0] s);
    load_mm = m; load_ss = s; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; cyc(1); abort = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; cyc(1); pause = 1'b0;
  endtask

  task automatic do_resume();
    resume = 1'b1; cyc(1); resume = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [7:0] m,
                         input logic [7:0] s, input logic tk, input logic tu, input logic w);
    chk({tag, ".state"},   16'(state),   16'(st));
    chk({tag, ".mm"},      16'(mm),      16'(m));
    chk({tag, ".ss"},      16'(ss),      16'(s));
    chk({tag, ".tick"},    16'(tick),    16'(tk));
    chk({tag, ".time_up"}, 16'(time_up), 16'(tu));
    chk({tag, ".warning"}, 16'(warning), 16'(w));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0;
    load_mm = 8'h00; load_ss = 8'h00;
    cyc(2);
    chk_all("reset", 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    cyc(1);

    // 00:03 countdown to expiry
    do_start(8'h00, 8'h03);
    chk_all("s03_load", 2'd1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1);
    cyc(3);
    chk_all("s03_pre3", 2'd1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b1);
    cyc(1);
    chk_all("s03_t1", 2'd1, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk("s03_t1_end.tick", 16'(tick), 16'd0);
    cyc(3);
    chk_all("s03_t2", 2'd1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1);
    cyc(4);
    chk_all("s03_exp", 2'd3, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_all("s03_exp1", 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(4);
    chk_all("s03_hold", 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_pause();
    chk("exp_pause_ign.state", 16'(state), 16'd3);

    // 01:00 borrow and warning window
    do_start(8'h01, 8'h00);
    chk_all("m1_load", 2'd1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(4);
    chk_all("m1_t1", 2'd1, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
    cyc(4 * 28);
    chk_all("m1_ss31", 2'd1, 8'h00, 8'h31, 1'b1, 1'b0, 1'b0);
    cyc(4);
    chk_all("m1_ss30", 2'd1, 8'h00, 8'h30, 1'b1, 1'b0, 1'b1);
    do_abort();
    chk_all("m1_abort", 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // 00:10, pause with prescaler at 2
    do_start(8'h00, 8'h10);
    chk("p_load.ss", 16'(ss), 16'h10);
    cyc(4);
    chk_all("p_t1", 2'd1, 8'h00, 8'h09, 1'b1, 1'b0, 1'b1);
    cyc(2);
    do_pause();
    chk_all("p_paused", 2'd2, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1);
    cyc(20);
    chk_all("p_frozen", 2'd2, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1);
    do_resume();
    chk_all("p_resume", 2'd1, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1);
    cyc(1);
    chk("p_res1.tick", 16'(tick), 16'd0);
    cyc(1);
    chk_all("p_res2", 2'd1, 8'h00, 8'h08, 1'b1, 1'b0, 1'b1);

    // pause coincident with prescaler at its top value
    cyc(3);
    do_pause();
    chk_all("pc_paused", 2'd2, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1);
    cyc(3);
    do_resume();
    chk_all("pc_resume", 2'd1, 8'h00, 8'h08, 1'b0, 1'b0, 1'b1);
    cyc(1);
    chk_all("pc_tick", 2'd1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b1);
    cyc(1);
    chk("pc_tick_end.tick", 16'(tick), 16'd0);
    do_start(8'h05, 8'h00);
    chk_all("run_start_ign", 2'd1, 8'h00, 8'h07, 1'b0, 1'b0, 1'b1);
    do_abort();
    do_resume();
    chk("idle_resume_ign.state", 16'(state), 16'd0);

    // load sanitising and minute borrow
    do_start(8'hA5, 8'h7C);
    chk_all("san_a5_7c", 2'd1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0);
    do_abort();
    do_start(8'h12, 8'h60);
    chk("san_12_60.mm", 16'(mm), 16'h12);
    chk("san_12_60.ss", 16'(ss), 16'h59);
    do_abort();
    do_start(8'h10, 8'h00);
    cyc(4);
    chk_all("m10_t1", 2'd1, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
    do_abort();
    do_start(8'h00, 8'h00);
    chk_all("zero_start", 2'd3, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_all("zero_start1", 2'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // abort while paused
    do_start(8'h00, 8'h20);
    chk_all("ap_load", 2'd1, 8'h00, 8'h20, 1'b0, 1'b0, 1'b1);
    do_pause();
    chk("ap_paused.state", 16'(state), 16'd2);
    do_abort();
    chk_all("ap_abort", 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-count
    do_start(8'h00, 8'h45);
    cyc(4);
    chk_all("ar_t1", 2'd1, 8'h00, 8'h44, 1'b1, 1'b0, 1'b0);
    #3 resetn = 1'b0;
    #1;
    chk_all("ar_async", 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(2);
    chk_all("ar_held", 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    cyc(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
